path_delay_gen: RTL and testbench

- Synthesizable, cycle-based realisation of specify-style module path delays (rise/fall) for LANES independent single-bit paths. Each path behaves as an inertial delay.
- Specify blocks declare path delays; this block produces them in hardware, for FPGA timing-behaviour models and for stimulus generators in the parser's regression benches.
- Pulses narrower than the programmed delay are cancelled (pulsestyle_onevent semantics).

---
 rtl/path_delay_pkg.sv | 17 +
 rtl/path_delay_lane.sv | 73 +++++++
 rtl/path_delay_gen.sv | 89 ++++++++
 tb/tb_path_delay_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_delay_pkg.sv
// Shared types and helpers for path_delay_gen: lane FSM state, default delay width,
// and the zero-to-one delay mapping.
package path_delay_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } lane_state_e;

  localparam int DLY_W_DEF = 8;

  // A programmed delay of 0 still needs one edge to register the output.
  function automatic logic [31:0] eff_delay(input logic [31:0] value);
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/path_delay_lane.sv
// One inertial-delay path: IDLE/PEND FSM, countdown and target bit. Change sampled at edge t
// reaches o_out at edge t+D unless reverted first. Optional o_cancel with PATH_DELAY_SHOWCANCELLED_EN.
module path_delay_lane
  import path_delay_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in,
  input  logic [DLY_W-1:0] i_rise,
  input  logic [DLY_W-1:0] i_fall,
  output logic             o_out,
  output logic             o_busy
`ifdef PATH_DELAY_SHOWCANCELLED_EN
  ,
  output logic             o_cancel
`endif
);

  lane_state_e      r_state;
  logic [DLY_W-1:0] r_cnt;
  logic             r_tgt;
  logic             r_out;

  logic             w_diff;
  logic [DLY_W-1:0] w_sel;
  logic [DLY_W-1:0] w_load;

  assign w_diff = i_in ^ r_out;
  assign w_sel  = i_in ? i_rise : i_fall;
  assign w_load = DLY_W'(eff_delay(32'(w_sel)) - 32'd1);

  // A revert always wins over expiry, so the cancel check comes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_diff) begin
            r_state <= PEND;
            r_cnt   <= w_load;
            r_tgt   <= i_in;
          end
        end
        PEND: begin
          if (!w_diff) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_out   <= r_tgt;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - DLY_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_busy = (r_state == PEND);

`ifdef PATH_DELAY_SHOWCANCELLED_EN
  assign o_cancel = (r_state == PEND) && !w_diff;
`endif

endmodule

// File: rtl/path_delay_gen.sv
// LANES independent inertial rise/fall path delays sharing one shadow config; all outputs registered.
// Define PATH_DELAY_SHOWCANCELLED_EN to add cancel_pulse and the saturating cancel_cnt.
module path_delay_gen
  import path_delay_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [DLY_W-1:0] cfg_rise,
  input  logic [DLY_W-1:0] cfg_fall,
  input  logic [LANES-1:0] in_sig,
  output logic [LANES-1:0] out_sig,
  output logic [LANES-1:0] busy
`ifdef PATH_DELAY_SHOWCANCELLED_EN
  ,
  output logic [LANES-1:0] cancel_pulse,
  output logic [15:0]      cancel_cnt
`endif
);

  logic [DLY_W-1:0] r_rise;
  logic [DLY_W-1:0] r_fall;

  // Lanes read the shadow copy, so a load at edge t only affects events scheduled after t.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= DLY_W'(1);
      r_fall <= DLY_W'(1);
    end else if (cfg_load) begin
      r_rise <= cfg_rise;
      r_fall <= cfg_fall;
    end
  end

`ifdef PATH_DELAY_SHOWCANCELLED_EN
  logic [LANES-1:0] w_cancel;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    path_delay_lane #(
      .DLY_W(DLY_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_in    (in_sig[g]),
      .i_rise  (r_rise),
      .i_fall  (r_fall),
      .o_out   (out_sig[g]),
      .o_busy  (busy[g])
`ifdef PATH_DELAY_SHOWCANCELLED_EN
      ,
      .o_cancel(w_cancel[g])
`endif
    );
  end

`ifdef PATH_DELAY_SHOWCANCELLED_EN
  logic [LANES-1:0] r_cancel_pulse;
  logic [15:0]      r_cancel_cnt;
  logic [5:0]       w_pop;
  logic [16:0]      w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + 6'(w_cancel[i]);
    end
  end

  assign w_sum = {1'b0, r_cancel_cnt} + 17'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cancel_pulse <= '0;
      r_cancel_cnt   <= '0;
    end else begin
      r_cancel_pulse <= w_cancel;
      r_cancel_cnt   <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign cancel_pulse = r_cancel_pulse;
  assign cancel_cnt   = r_cancel_cnt;
`endif

endmodule

// File: tb/tb_path_delay_gen.sv
// Directed bench for path_delay_gen: output transitions are matched against a scoreboard of
// expected (lane, value, edge) entries; cancel checks run when PATH_DELAY_SHOWCANCELLED_EN is set.
module tb_path_delay_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_rise;
  logic [7:0] cfg_fall;
  logic [3:0] in_sig;
  logic [3:0] out_sig;
  logic [3:0] busy;
`ifdef PATH_DELAY_SHOWCANCELLED_EN
  logic [3:0]  cancel_pulse;
  logic [15:0] cancel_cnt;
`endif

  path_delay_gen #(
    .LANES(4),
    .DLY_W(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_rise    (cfg_rise),
    .cfg_fall    (cfg_fall),
    .in_sig      (in_sig),
    .out_sig     (out_sig),
    .busy        (busy)
`ifdef PATH_DELAY_SHOWCANCELLED_EN
    ,
    .cancel_pulse(cancel_pulse),
    .cancel_cnt  (cancel_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane;
    bit val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [3:0] prev_out = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called after driving an input, before the edge that samples it.
  task automatic exp_out(input int lane, input bit val, input int d);
    exp_t e;
    e.lane = lane;
    e.val  = val;
    e.cyc  = cyc + 1 + d;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [7:0] r, input logic [7:0] f);
    cfg_rise = r;
    cfg_fall = f;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic glitch(input logic [3:0] m);
    in_sig = m;
    step();
    in_sig = 4'h0;
    step();
  endtask

  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_sig[i] !== prev_out[i]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].lane == i) idx = k;
          end
          if (idx < 0) begin
            chk($sformatf("unexpected_out_lane%0d", i), 32'(out_sig[i]), 32'(prev_out[i]));
          end else begin
            chk($sformatf("sb_val_lane%0d", i), 32'(out_sig[i]), 32'(sb[idx].val));
            chk($sformatf("sb_edge_lane%0d", i), cyc, sb[idx].cyc);
            sb.delete(idx);
          end
        end
      end
    end
    prev_out = out_sig;
  end

  initial begin
    rst_n    = 1'b0;
    cfg_load = 1'b0;
    cfg_rise = 8'd0;
    cfg_fall = 8'd0;
    in_sig   = 4'h0;
    step(3);
    chk("rst_out", 32'(out_sig), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Lane 0: rise 3, fall 5
    cfg(8'd3, 8'd5);
    in_sig[0] = 1'b1;
    exp_out(0, 1'b1, 3);
    step();
    chk("t1_busy_e0", 32'(busy[0]), 32'h1);
    step(2);
    chk("t1_busy_e2", 32'(busy[0]), 32'h1);
    chk("t1_out_e2", 32'(out_sig[0]), 32'h0);
    step();
    chk("t1_out_e3", 32'(out_sig[0]), 32'h1);
    chk("t1_busy_e3", 32'(busy[0]), 32'h0);
    step(3);
    in_sig[0] = 1'b0;
    exp_out(0, 1'b0, 5);
    step(5);
    chk("t1_fall_e4", 32'(out_sig[0]), 32'h1);
    step();
    chk("t1_fall_e5", 32'(out_sig[0]), 32'h0);

    // Lane 1: two-cycle pulse against rise 4 is swallowed
    cfg(8'd4, 8'd5);
    in_sig[1] = 1'b1;
    step();
    chk("t2_busy", 32'(busy[1]), 32'h1);
    step();
    in_sig[1] = 1'b0;
    step();
    chk("t2_busy_revert", 32'(busy[1]), 32'h0);
    chk("t2_out_revert", 32'(out_sig[1]), 32'h0);
`ifdef PATH_DELAY_SHOWCANCELLED_EN
    chk("t2_cancel_pulse", 32'(cancel_pulse), 32'h2);
    chk("t2_cancel_cnt", 32'(cancel_cnt), 32'd1);
`endif
    step();
`ifdef PATH_DELAY_SHOWCANCELLED_EN
    chk("t2_cancel_pulse_end", 32'(cancel_pulse), 32'h0);
`endif
    step(4);
    chk("t2_out_quiet", 32'(out_sig[1]), 32'h0);

    // Lane 2: rise 0 behaves as 1
    cfg(8'd0, 8'd5);
    in_sig[2] = 1'b1;
    exp_out(2, 1'b1, 1);
    step();
    chk("t3_busy", 32'(busy[2]), 32'h1);
    step();
    chk("t3_out", 32'(out_sig[2]), 32'h1);
    chk("t3_busy_done", 32'(busy[2]), 32'h0);
    in_sig[2] = 1'b0;
    exp_out(2, 1'b0, 5);
    step(6);

    // Lane 3: revert lands on the expiry edge
    cfg(8'd2, 8'd5);
    in_sig[3] = 1'b1;
    step(2);
    in_sig[3] = 1'b0;
    step();
    chk("t4_out_cancel", 32'(out_sig[3]), 32'h0);
    chk("t4_busy_cancel", 32'(busy[3]), 32'h0);
`ifdef PATH_DELAY_SHOWCANCELLED_EN
    chk("t4_cancel_cnt", 32'(cancel_cnt), 32'd2);
`endif

    // Lane 3: revert then re-assert gets a fresh full countdown
    in_sig[3] = 1'b1;
    step();
    in_sig[3] = 1'b0;
    step();
    in_sig[3] = 1'b1;
    exp_out(3, 1'b1, 2);
    step();
    chk("t4b_busy_fresh", 32'(busy[3]), 32'h1);
    step();
    chk("t4b_no_credit", 32'(out_sig[3]), 32'h0);
    step();
    chk("t4b_out", 32'(out_sig[3]), 32'h1);
`ifdef PATH_DELAY_SHOWCANCELLED_EN
    chk("t4b_cancel_cnt", 32'(cancel_cnt), 32'd3);
`endif
    in_sig[3] = 1'b0;
    exp_out(3, 1'b0, 5);
    step(6);

    // Lane 0: reconfigure during an active countdown
    cfg(8'd10, 8'd5);
    in_sig[0] = 1'b1;
    exp_out(0, 1'b1, 10);
    step();
    cfg(8'd2, 8'd5);
    step(7);
    chk("t5_inflight_busy", 32'(busy[0]), 32'h1);
    chk("t5_inflight_out", 32'(out_sig[0]), 32'h0);
    step(2);
    chk("t5_inflight_done", 32'(out_sig[0]), 32'h1);
    in_sig[0] = 1'b0;
    exp_out(0, 1'b0, 5);
    step(6);
    in_sig[0] = 1'b1;
    exp_out(0, 1'b1, 2);
    step(3);
    chk("t5_new_rise", 32'(out_sig[0]), 32'h1);
    in_sig[0] = 1'b0;
    exp_out(0, 1'b0, 5);
    step(6);

    // All lanes pending, then asynchronous reset
    in_sig = 4'hF;
    step();
    chk("t6_busy_all", 32'(busy), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_out", 32'(out_sig), 32'h0);
    in_sig = 4'h0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("t6_idle_busy", 32'(busy), 32'h0);
    chk("t6_idle_out", 32'(out_sig), 32'h0);

    // Shadow config back at 1/1 after reset
    in_sig[1] = 1'b1;
    exp_out(1, 1'b1, 1);
    step(2);
    chk("t6_shadow_rise", 32'(out_sig[1]), 32'h1);
    in_sig[1] = 1'b0;
    exp_out(1, 1'b0, 1);
    step(2);

`ifdef PATH_DELAY_SHOWCANCELLED_EN
    cfg(8'd2, 8'd2);
    chk("t7_cnt_start", 32'(cancel_cnt), 32'd0);
    repeat (16382) glitch(4'hF);
    chk("t7_cnt_fff8", 32'(cancel_cnt), 32'hFFF8);
    glitch(4'hF);
    chk("t7_pulse_all", 32'(cancel_pulse), 32'hF);
    chk("t7_cnt_fffc", 32'(cancel_cnt), 32'hFFFC);
    glitch(4'h1);
    glitch(4'h1);
    chk("t7_cnt_fffe", 32'(cancel_cnt), 32'hFFFE);
    glitch(4'hF);
    chk("t7_cnt_sat", 32'(cancel_cnt), 32'hFFFF);
    glitch(4'hF);
    chk("t7_cnt_hold", 32'(cancel_cnt), 32'hFFFF);
`endif

    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
